noc_packet_injector_mux: RTL and testbench
==========================================

Name: noc_packet_injector_mux

Overview:
- Parametrised successor to the single-stream task/app injectors that feed the many-core's external NoC injection ports.
- Merges N_SRC credit-based flit streams into one credit-based injection port.
- Each source gets its own buffer. Grants are packet-atomic and round-robin.
- Aggregates the per-source end-of-application flags into a single eoa_o, asserted only once every buffer has drained.

Parameters:
- N_SRC, 2, number of source channels (>=1).
- FLIT_SIZE, 32, flit width in bits.
- BUF_DEPTH, 4, flits per source FIFO (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- src_rx_i  in  N_SRC  per-source flit valid.
- src_credit_o  out  N_SRC  per-source ready.
- src_data_i  in  N_SRC*FLIT_SIZE  per-source flit; source k occupies bits [k*FLIT_SIZE +: FLIT_SIZE].
- src_eoa_i  in  N_SRC  per-source end-of-application flag.
- tx_o  out  1  output flit valid.
- credit_i  in  1  downstream ready.
- data_o  out  FLIT_SIZE  output flit.
- eoa_o  out  1  all sources finished and fully drained.
- grant_o  out  max(1,$clog2(N_SRC))  index of the source currently granted.
- busy_o  out  1  a packet is in flight (state != IDLE).

Behaviour:
- Handshakes:
  - Source write occurs when src_rx_i[k] & src_credit_o[k].
  - Output transfer occurs when tx_o & credit_i.
  - Data is held stable while tx_o=1 and credit_i=0.
- Credit: src_credit_o[k] = (count[k] != BUF_DEPTH), combinational from registered count.
- FIFO:
  - Memory and pointers are registered; pointers wrap modulo BUF_DEPTH.
  - A write and a read on the same FIFO in the same cycle leaves count unchanged.
  - A write is impossible when full because credit is low.
  - A read of an empty FIFO never occurs.
- Packet format: flit0 = header (target); flit1 = payload size S (unsigned, FLIT_SIZE bits); then S payload flits. Total S+2 flits.
- FSM states:
  - IDLE:
    - Round-robin search starting at last_grant+1 (mod N_SRC) for the first FIFO with count!=0.
    - On a hit, register grant and go to HEAD. IDLE itself does not transmit.
  - HEAD: tx_o = (count[grant]!=0); on transfer go to SIZE.
  - SIZE:
    - On transfer, latch remaining = data_o.
    - If data_o==0, go to IDLE and set last_grant=grant. Otherwise go to PAYLOAD.
  - PAYLOAD:
    - Each transfer decrements remaining.
    - The transfer with remaining==1 goes to IDLE and sets last_grant=grant.
- Output path:
  - data_o = head of FIFO[grant] while in HEAD/SIZE/PAYLOAD, else 0.
  - tx_o = 0 in IDLE.
  - tx_o drops (bubble) whenever the granted FIFO is empty mid-packet; the grant is held and never switches mid-packet.
- Latency: a flit written at edge t into an empty FIFO with the FSM idle is seen by arbitration in cycle t+1, and tx_o=1 from cycle t+2.
- Back-to-back packets: one IDLE cycle between the last flit of one packet and the header of the next.
- eoa_o:
  - Registered, 1 the cycle after &src_eoa_i, all FIFO counts 0 and state IDLE hold simultaneously.
  - Returns to 0 the cycle after any of these conditions fails.
- Reset (including mid-packet):
  - FIFOs flushed (counts/pointers 0), state IDLE, remaining 0, last_grant=N_SRC-1 so source 0 has first priority, grant 0.
  - Outputs: tx_o=0, data_o=0, eoa_o=0, busy_o=0, grant_o=0.
  - src_credit_o becomes all-ones once counts are 0, i.e. from the cycle after the reset edge.
  - Partially sent packets are dropped, not resumed.
- N_SRC=1 degenerates to a packet-aware FIFO; grant_o is tied to 0.

Test Plan:
- Single source, credit_i=1: src0 sends {0x0101, 2, 0xA, 0xB} from cycle 0. Required: tx_o rises at cycle 2; data_o = 0x0101, 2, 0xA, 0xB on consecutive cycles; busy_o falls after 0xB.
- Contention: src0 and src1 each load {H, 1, P} in the same cycle. Required: src0 packet sent complete first, grant_o=0; then one IDLE cycle; then src1 packet, grant_o=1. A repeat burst is served starting from src0 again.
- Zero-size packet: src1 sends {0x0203, 0}. Required: exactly 2 flits out, FSM back in IDLE, last_grant=1.
- Backpressure with BUF_DEPTH=4 and credit_i=0: src0 pushes 6 flits. Required: src_credit_o[0]=0 after 4 writes. After credit_i=1, all 6 flits emerge in order with no loss or duplication; data_o is stable while stalled.
- Starvation bubble: src0 sends {H, 3, P0}, then stalls 5 cycles before P1, P2 while src1 holds a full packet. Required: tx_o=0 during the gap; grant_o stays 0 until P2 is sent; src1 packet follows.
- Reset and eoa: assert rst_i mid-payload. Required: tx_o=0 next cycle and FIFOs empty. Then assert all src_eoa_i with empty buffers: eoa_o=1 one cycle later. Pushing a flit on src0 drops eoa_o.

Source files
------------

// File: rtl/noc_packet_injector_mux.sv
// noc_packet_injector_mux
// Merges N_SRC credit-based flit streams into one credit-based NoC injection
// port. Every source owns a small FIFO; a round-robin arbiter grants whole
// packets (header, size, payload) so flits of different packets never
// interleave. eoa_o reports that every source has finished and all buffers
// have drained.
module noc_packet_injector_mux #(
  parameter int N_SRC     = 2,
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 4,
  localparam int GW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SRC-1:0]           src_rx_i,
  output logic [N_SRC-1:0]           src_credit_o,
  input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
  input  logic [N_SRC-1:0]           src_eoa_i,
  output logic                       tx_o,
  input  logic                       credit_i,
  output logic [FLIT_SIZE-1:0]       data_o,
  output logic                       eoa_o,
  output logic [GW-1:0]              grant_o,
  output logic                       busy_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEAD    = 2'd1;
  localparam logic [1:0] ST_SIZE    = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  logic [FLIT_SIZE-1:0] mem [N_SRC][BUF_DEPTH];
  logic [PW-1:0]        wr_ptr [N_SRC];
  logic [PW-1:0]        rd_ptr [N_SRC];
  logic [CW-1:0]        count  [N_SRC];

  logic [N_SRC-1:0]     wr_en;
  logic [N_SRC-1:0]     rd_en;
  logic [N_SRC-1:0]     not_empty;

  logic [1:0]           state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        pick;
  logic                 found;
  logic [FLIT_SIZE-1:0] remaining;
  logic [FLIT_SIZE-1:0] head_flit;
  logic                 xfer;
  int                   idx;

  // Per-source credit, write acceptance and occupancy flags from registered counts
  always_comb begin
    src_credit_o = '0;
    wr_en        = '0;
    not_empty    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      src_credit_o[k] = (count[k] != FULL);
      wr_en[k]        = src_rx_i[k] & (count[k] != FULL);
      not_empty[k]    = (count[k] != '0);
    end
  end

  // Output side: only the granted FIFO is visible, and only while a packet is open
  always_comb begin
    head_flit = mem[grant][rd_ptr[grant]];
    busy_o    = (state != ST_IDLE);
    tx_o      = (state != ST_IDLE) && not_empty[grant];
    data_o    = (state != ST_IDLE) ? head_flit : '0;
    xfer      = tx_o & credit_i;
  end

  // Pop the granted FIFO whenever the downstream accepts a flit
  always_comb begin
    rd_en = '0;
    for (int k = 0; k < N_SRC; k++) begin
      rd_en[k] = xfer && (grant == GW'(k));
    end
  end

  // Round-robin search starting just after the source that finished last
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(last_grant) + i) % N_SRC;
      if (!found && not_empty[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // FIFO storage; contents need no reset because counts gate every read
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_SRC; k++) begin
      if (wr_en[k]) begin
        mem[k][wr_ptr[k]] <= src_data_i[k*FLIT_SIZE +: FLIT_SIZE];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at BUF_DEPTH
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_SRC; k++) begin
      if (rst_i) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end else begin
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
        if (rd_en[k]) rd_ptr[k] <= rd_ptr[k] + PW'(1);
        count[k] <= count[k] + CW'(wr_en[k]) - CW'(rd_en[k]);
      end
    end
  end

  // Packet FSM: grant held from header to last payload flit, then one idle cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(N_SRC - 1);
      remaining  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= pick;
            state <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (xfer) state <= ST_SIZE;
        end
        ST_SIZE: begin
          if (xfer) begin
            remaining <= data_o;
            if (data_o == '0) begin
              state      <= ST_IDLE;
              last_grant <= grant;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            remaining <= remaining - FLIT_SIZE'(1);
            if (remaining == FLIT_SIZE'(1)) begin
              state      <= ST_IDLE;
              last_grant <= grant;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // End of application only once every source is done and nothing is left to send
  always_ff @(posedge clk_i) begin
    if (rst_i) eoa_o <= 1'b0;
    else       eoa_o <= (&src_eoa_i) && !(|not_empty) && (state == ST_IDLE);
  end

  generate
    if (N_SRC == 1) begin : g_single
      assign grant_o = '0;
    end else begin : g_multi
      assign grant_o = grant;
    end
  endgenerate

endmodule

// File: tb/tb_noc_packet_injector_mux.sv
// tb_noc_packet_injector_mux
// Directed bench: a cycle-by-cycle vector table for single-source, contention
// and zero-size packets, followed by hand-written sequences for backpressure,
// mid-packet starvation, reset mid-payload and end-of-application.
module tb_noc_packet_injector_mux;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  src_rx_i;
  logic [1:0]  src_credit_o;
  logic [63:0] src_data_i;
  logic [1:0]  src_eoa_i;
  logic        tx_o;
  logic        credit_i;
  logic [31:0] data_o;
  logic        eoa_o;
  logic [0:0]  grant_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  rx;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        exp_tx;
    logic [31:0] exp_data;
    logic        exp_grant;
    logic        exp_busy;
    logic [1:0]  exp_credit;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] dflits [6];
  logic [31:0] cap_d[$];
  logic [31:0] cap_g[$];
  logic [31:0] e_exp_d [8];
  logic [31:0] e_exp_g [8];
  int          sent;
  int          got;
  int          stall_bad;
  int          bubbles;
  logic        cred_last;
  logic        hit;

  noc_packet_injector_mux #(
    .N_SRC(2),
    .FLIT_SIZE(32),
    .BUF_DEPTH(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .src_rx_i(src_rx_i),
    .src_credit_o(src_credit_o),
    .src_data_i(src_data_i),
    .src_eoa_i(src_eoa_i),
    .tx_o(tx_o),
    .credit_i(credit_i),
    .data_o(data_o),
    .eoa_o(eoa_o),
    .grant_o(grant_o),
    .busy_o(busy_o)
  );

  // Free-running 10 ns clock
  always #5 clk_i = ~clk_i;

  // Safety net in case a sequence never terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void add(input logic rst, input logic [1:0] rx,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic etx, input logic [31:0] edata,
                              input logic egrant, input logic ebusy,
                              input logic [1:0] ecredit);
    vec_t v;
    v.rst = rst; v.rx = rx; v.d0 = d0; v.d1 = d1;
    v.exp_tx = etx; v.exp_data = edata; v.exp_grant = egrant;
    v.exp_busy = ebusy; v.exp_credit = ecredit;
    vecs.push_back(v);
  endfunction

  task applyStimulus(input vec_t v);
    rst_i      = v.rst;
    src_rx_i   = v.rx;
    src_data_i = {v.d1, v.d0};
    credit_i   = 1'b1;
    src_eoa_i  = 2'b00;
  endtask

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; src_rx_i = '0; src_data_i = '0; src_eoa_i = '0; credit_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // single source {0x0101, 2, 0xA, 0xB}
    add(0, 2'b01, 32'h0101, 0, 0, 0,       0, 0, 2'b11);
    add(0, 2'b01, 32'h2,    0, 0, 0,       0, 0, 2'b11);
    add(0, 2'b01, 32'hA,    0, 1, 32'h0101,0, 1, 2'b11);
    add(0, 2'b01, 32'hB,    0, 1, 32'h2,   0, 1, 2'b11);
    add(0, 2'b00, 0,        0, 1, 32'hA,   0, 1, 2'b11);
    add(0, 2'b00, 0,        0, 1, 32'hB,   0, 1, 2'b11);
    add(0, 2'b00, 0,        0, 0, 0,       0, 0, 2'b11);
    // reset so source 0 has priority again
    add(1, 2'b00, 0,        0, 0, 0,       0, 0, 2'b11);
    // contention, first burst
    add(0, 2'b11, 32'h1000, 32'h2000, 0, 0,        0, 0, 2'b11);
    add(0, 2'b11, 32'h1,    32'h1,    0, 0,        0, 0, 2'b11);
    add(0, 2'b11, 32'h11,   32'h22,   1, 32'h1000, 0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h1,    0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h11,   0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               0, 0,        0, 0, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h2000, 1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h1,    1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h22,   1, 1, 2'b11);
    // contention, repeat burst starts from source 0 again
    add(0, 2'b11, 32'h3000, 32'h4000, 0, 0,        1, 0, 2'b11);
    add(0, 2'b11, 32'h1,    32'h1,    0, 0,        1, 0, 2'b11);
    add(0, 2'b11, 32'h33,   32'h44,   1, 32'h3000, 0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h1,    0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h33,   0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               0, 0,        0, 0, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h4000, 1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h1,    1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h44,   1, 1, 2'b11);
    // zero-size packet on source 1
    add(0, 2'b10, 0, 32'h0203,        0, 0,        1, 0, 2'b11);
    add(0, 2'b10, 0, 32'h0,           0, 0,        1, 0, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h0203, 1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h0,    1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               0, 0,        1, 0, 2'b11);
    // last_grant is 1 now, so source 0 wins the next tie
    add(0, 2'b11, 32'h0500, 32'h0600, 0, 0,        1, 0, 2'b11);
    add(0, 2'b11, 32'h0,    32'h0,    0, 0,        1, 0, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h0500, 0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h0,    0, 1, 2'b11);
    add(0, 2'b00, 0, 0,               0, 0,        0, 0, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h0600, 1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               1, 32'h0,    1, 1, 2'b11);
    add(0, 2'b00, 0, 0,               0, 0,        1, 0, 2'b11);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d_tx", i),     32'(tx_o),         32'(vecs[i].exp_tx));
      checkOutput($sformatf("row%0d_data", i),   data_o,            vecs[i].exp_data);
      checkOutput($sformatf("row%0d_grant", i),  32'(grant_o),      32'(vecs[i].exp_grant));
      checkOutput($sformatf("row%0d_busy", i),   32'(busy_o),       32'(vecs[i].exp_busy));
      checkOutput($sformatf("row%0d_credit", i), 32'(src_credit_o), 32'(vecs[i].exp_credit));
      checkOutput($sformatf("row%0d_eoa", i),    32'(eoa_o),        32'd0);
      @(posedge clk_i);
    end

    // backpressure: six flits into a four-deep FIFO with downstream stalled
    dflits[0] = 32'h0D00; dflits[1] = 32'h4;    dflits[2] = 32'hD1;
    dflits[3] = 32'hD2;   dflits[4] = 32'hD3;   dflits[5] = 32'hD4;
    sent = 0; stall_bad = 0; cred_last = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      credit_i   = 1'b0;
      src_rx_i   = {1'b0, (sent < 6)};
      src_data_i = {32'h0, dflits[(sent < 6) ? sent : 0]};
      #1;
      if (c >= 2 && !(tx_o && data_o == 32'h0D00)) stall_bad++;
      if (src_rx_i[0] && src_credit_o[0]) sent++;
      cred_last = src_credit_o[0];
      @(posedge clk_i);
    end
    checkOutput("bp_writes", 32'(sent), 32'd4);
    checkOutput("bp_credit_low", 32'(cred_last), 32'd0);
    checkOutput("bp_stall_hold", 32'(stall_bad), 32'd0);
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk_i);
      credit_i   = 1'b1;
      src_rx_i   = {1'b0, (sent < 6)};
      src_data_i = {32'h0, dflits[(sent < 6) ? sent : 0]};
      #1;
      if (tx_o && credit_i) begin cap_d.push_back(data_o); got++; end
      if (src_rx_i[0] && src_credit_o[0]) sent++;
      @(posedge clk_i);
    end
    checkOutput("bp_count", 32'(got), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < cap_d.size()) checkOutput($sformatf("bp_flit%0d", i), cap_d[i], dflits[i]);
    end
    @(negedge clk_i);
    src_rx_i = '0;
    #1;
    checkOutput("bp_no_dup", 32'(tx_o), 32'd0);

    // starvation bubble: source 0 stalls mid-payload while source 1 waits
    e_exp_d[0] = 32'h0E00; e_exp_d[1] = 32'h3; e_exp_d[2] = 32'hE0; e_exp_d[3] = 32'hE1;
    e_exp_d[4] = 32'hE2;   e_exp_d[5] = 32'h0F00; e_exp_d[6] = 32'h1; e_exp_d[7] = 32'hF1;
    for (int i = 0; i < 8; i++) e_exp_g[i] = (i < 5) ? 32'd0 : 32'd1;
    cap_d.delete(); cap_g.delete();
    got = 0; bubbles = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk_i);
      credit_i = 1'b1; src_rx_i = '0; src_data_i = '0;
      case (c)
        0: begin src_rx_i = 2'b01; src_data_i = {32'h0,    32'h0E00}; end
        1: begin src_rx_i = 2'b11; src_data_i = {32'h0F00, 32'h3};    end
        2: begin src_rx_i = 2'b11; src_data_i = {32'h1,    32'hE0};   end
        3: begin src_rx_i = 2'b10; src_data_i = {32'hF1,   32'h0};    end
        8: begin src_rx_i = 2'b01; src_data_i = {32'h0,    32'hE1};   end
        9: begin src_rx_i = 2'b01; src_data_i = {32'h0,    32'hE2};   end
        default: ;
      endcase
      #1;
      if (busy_o && !tx_o && grant_o == 1'b0) bubbles++;
      if (tx_o && credit_i) begin
        cap_d.push_back(data_o);
        cap_g.push_back(32'(grant_o));
        got++;
      end
      @(posedge clk_i);
    end
    checkOutput("starve_count", 32'(got), 32'd8);
    checkOutput("starve_bubbles", 32'(bubbles), 32'd4);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_d.size()) begin
        checkOutput($sformatf("starve_data%0d", i),  cap_d[i], e_exp_d[i]);
        checkOutput($sformatf("starve_grant%0d", i), cap_g[i], e_exp_g[i]);
      end
    end

    // reset in the middle of a payload drops the packet
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk_i);
      credit_i = 1'b1; src_rx_i = '0; src_data_i = '0;
      case (c)
        0: begin src_rx_i = 2'b01; src_data_i = {32'h0, 32'h0A00}; end
        1: begin src_rx_i = 2'b01; src_data_i = {32'h0, 32'h5};    end
        2: begin src_rx_i = 2'b01; src_data_i = {32'h0, 32'hA1};   end
        3: begin src_rx_i = 2'b01; src_data_i = {32'h0, 32'hA2};   end
        default: ;
      endcase
      #1;
      if (tx_o && data_o == 32'hA1) hit = 1'b1;
      else @(posedge clk_i);
    end
    checkOutput("rst_reach_payload", 32'(hit), 32'd1);
    rst_i = 1'b1; src_rx_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("rst_tx",     32'(tx_o),         32'd0);
    checkOutput("rst_busy",   32'(busy_o),       32'd0);
    checkOutput("rst_data",   data_o,            32'd0);
    checkOutput("rst_grant",  32'(grant_o),      32'd0);
    checkOutput("rst_credit", 32'(src_credit_o), 32'd3);
    checkOutput("rst_eoa",    32'(eoa_o),        32'd0);
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("rst_dropped_tx",   32'(tx_o),   32'd0);
    checkOutput("rst_dropped_busy", 32'(busy_o), 32'd0);

    // end of application aggregation
    src_eoa_i = 2'b01;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("eoa_partial", 32'(eoa_o), 32'd0);
    src_eoa_i = 2'b11;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("eoa_set", 32'(eoa_o), 32'd1);
    src_rx_i = 2'b01; src_data_i = {32'h0, 32'h0B00};
    @(posedge clk_i);
    @(negedge clk_i);
    src_rx_i = '0;
    #1;
    checkOutput("eoa_hold", 32'(eoa_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("eoa_drop", 32'(eoa_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
